gp0_cmd_queue: RTL
==================

Name: gp0_cmd_queue

Overview:
Upstream feeder for the gpu block. Accepts 32-bit GP0 writes from the main bus (CPU store or DMA), buffers them in a FIFO, and delineates packets by decoding each GP0 opcode's word count. The gpu consumes one word per handshake, with first/last-of-packet markers. Also produces the GPUSTAT "ready" bits and handles the GP1 reset commands that flush the command path.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=4)
LVL_W, $clog2(DEPTH)+1, width of the level output

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (low = reset)
to_gp0  in  1  one-cycle strobe: main_bus carries a GP0 word
to_gp1  in  1  one-cycle strobe: main_bus carries a GP1 word
main_bus  in  32  write data
cmd_word  out  32  FIFO head word
cmd_valid  out  1  head word is valid
cmd_first  out  1  head is the first word of a packet
cmd_last  out  1  head is the last word of a packet
cmd_ack  in  1  gpu pops head (honoured only when cmd_valid)
rdy_cmd  out  1  GPUSTAT bit 26
rdy_dma  out  1  GPUSTAT bit 28
overflow  out  1  sticky flag: a GP0 word was dropped
level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset (rst low, async): FIFO empty, decoder in HEAD, overflow=0, level=0. Consequently cmd_valid=0, cmd_first=0, cmd_last=0, rdy_cmd=1, rdy_dma=1. cmd_word=0.
- Push: to_gp0 and not full -> main_bus is written on that edge. to_gp0 and full -> word dropped, overflow set. Simultaneous push and pop when full -> push accepted.
- Head is first-word-fall-through: cmd_valid=!empty, cmd_word=mem[rd_ptr]. Pop on cmd_valid&&cmd_ack. Write-to-valid latency is 1 cycle.
- GP1 flush: to_gp1 with main_bus[31:24]==8'h00 or 8'h01 clears the FIFO and returns the decoder to HEAD on that edge. Opcode 00 additionally clears overflow. Flush beats a same-cycle push (word dropped, no overflow) and a same-cycle pop. Other GP1 opcodes are ignored.
- Decoder tracks the head word. It advances only on pop. The remaining-word counter rem is 20 bits wide.
- States:
  - HEAD: cmd_first=1. Decode op=word[31:24] and load rem.
    - 0x20-0x3F polygon: n=word[27]?4:3. Total = 1 + n + (word[26]?n:0) + (word[28]?n-1:0).
    - 0x40-0x5F line: word[27]=0 -> 3 words flat / 4 words gouraud (word[28]). word[27]=1 -> POLYLINE.
    - 0x60-0x7F rect: 2 + (word[26]) + (word[28:27]==0).
    - 0x02: 3. 0x80-0x9F: 4. 0xA0-0xBF: 3, then XFER. 0xC0-0xDF: 3.
    - All others: 1.
    - If total==1, cmd_last=1 and the state stays HEAD. Otherwise go to PARAM.
  - PARAM: cmd_last when rem==1. On pop of the last word go to HEAD. For A0, on pop of word index 2: W=((w[15:0]-1)&0x3FF)+1, H=((w[31:16]-1)&0x1FF)+1, rem=(W*H+1)>>1, then go to XFER. In this case word 2 is not cmd_last.
  - XFER: cmd_last when rem==1. Go to HEAD after the last pop.
  - POLYLINE: count vertex words (shaded: colour/vertex pairs). A head word is cmd_last when (w & 32'hF000F000)==32'h50005000 and at least 2 vertices have been popped. Return to HEAD after popping it.
- rdy_cmd = empty && state==HEAD (combinational).
- rdy_dma = level < DEPTH-1.
- level counts pushes minus pops and saturates at DEPTH.

Decomposition:
- Shared package gpu_pkg:
  - GP0 opcode-range constants
  - GP1 flush opcodes (GP1_RESET=8'h00, GP1_CMDRST=8'h01)
  - POLYLINE_TERM mask/value
  - gp0_state_t enum {HEAD, PARAM, XFER, POLYLINE}
  - function gp0_len(logic [31:0]) returning the fixed packet length
- One sub-module gp0_fifo: DEPTH x 32 synchronous FIFO with FWFT head, full/empty, level and flush input.
- Decoder and status logic live in gp0_cmd_queue.

Test Plan:
- Push 0x28000000 plus 4 vertex words, cmd_ack=1 -> cmd_first on word 0 only, cmd_last on word 4 only, rdy_cmd=1 one cycle after the final pop.
- Push 0xA0000000, 0x00000000, 0x00020003, then 3 data words -> last asserted only on the 6th word; with 0x00000000 size, rem=1024*512/2=262144.
- Push 0x48000000, 3 vertices, 0x55555555 -> cmd_last only on 0x55555555 (5th word). A 0x50005000 word as the 2nd word is not a terminator.
- cmd_ack=0 with 17 pushes -> level=16 and stays saturated, rdy_dma=0, overflow=1, 17th word absent. GP1 0x01000000 -> empty, overflow still 1. GP1 0x00000000 -> overflow=0.
- GP1 0x01000000 in the same cycle as a push, during PARAM of a quad -> next cycle: cmd_valid=0, state HEAD, then a new 0xE1000000 pops with first=last=1.
- rst low mid-XFER, asynchronous to clk -> all outputs reach reset values immediately. After release, the next word is decoded as HEAD.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GP0/GP1 definitions for the gpu command path: opcode groups,
// flush opcodes, polyline terminator, decoder states and packet-length helpers.
package gpu_pkg;

   // GP0 opcode groups, selected by op[7:5]
   localparam logic [2:0] OPC_POLY     = 3'b001;
   localparam logic [2:0] OPC_LINE     = 3'b010;
   localparam logic [2:0] OPC_RECT     = 3'b011;
   localparam logic [2:0] OPC_COPY     = 3'b100;
   localparam logic [2:0] OPC_CPU2VRAM = 3'b101;
   localparam logic [2:0] OPC_VRAM2CPU = 3'b110;
   localparam logic [7:0] OP_FILL      = 8'h02;

   localparam logic [7:0] GP1_RESET  = 8'h00;
   localparam logic [7:0] GP1_CMDRST = 8'h01;

   localparam logic [31:0] POLYLINE_TERM_MASK = 32'hF000F000;
   localparam logic [31:0] POLYLINE_TERM_VAL  = 32'h50005000;

   typedef enum logic [1:0] {HEAD, PARAM, XFER, POLYLINE} gp0_state_t;

   // Fixed packet length in words; polylines are open-ended and report 0.
   function automatic logic [3:0] gp0_len(input logic [31:0] w);
      logic [3:0] n;
      n = w[27] ? 4'd4 : 4'd3;
      case (w[31:29])
         OPC_POLY:     gp0_len = 4'd1 + n + (w[26] ? n : 4'd0) + (w[28] ? n - 4'd1 : 4'd0);
         OPC_LINE:     gp0_len = w[27] ? 4'd0 : (w[28] ? 4'd4 : 4'd3);
         OPC_RECT:     gp0_len = 4'd2 + {3'd0, w[26]} + {3'd0, (w[28:27] == 2'b00)};
         OPC_COPY:     gp0_len = 4'd4;
         OPC_CPU2VRAM: gp0_len = 4'd3;
         OPC_VRAM2CPU: gp0_len = 4'd3;
         default:      gp0_len = (w[31:24] == OP_FILL) ? 4'd3 : 4'd1;
      endcase
   endfunction

   // Halfword pairs in a CPU->VRAM transfer; a zero size field means the maximum.
   function automatic logic [19:0] xfer_words(input logic [9:0] w_fld, input logic [8:0] h_fld);
      logic [20:0] wd;
      logic [20:0] ht;
      logic [20:0] prod;
      wd   = {11'd0, w_fld - 10'd1} + 21'd1;
      ht   = {12'd0, h_fld - 9'd1} + 21'd1;
      prod = wd * ht;
      xfer_words = 20'((prod + 21'd1) >> 1);
   endfunction

endpackage

// File: rtl/gp0_fifo.sv
// DEPTH x 32 synchronous FIFO with first-word-fall-through head and a flush
// that empties it in one cycle, overriding any same-cycle push or pop.
module gp0_fifo #(
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [31:0]      wdata,
   input  logic             pop,
   output logic [31:0]      rdata,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign empty = (level == '0);
   assign full  = (level == LVL_W'(DEPTH));

   // A pop frees the slot this cycle, so a push into a full FIFO still lands.
   assign pop_ok  = pop && !empty && !flush;
   assign push_ok = push && !flush && (!full || pop_ok);

   // Gate the head so it reads zero whenever nothing valid is stored.
   assign rdata = empty ? 32'd0 : mem[rd_ptr];

   // NOTE: storage has no reset; validity is carried entirely by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop_ok)      level <= level + LVL_W'(1);
         else if (pop_ok && !push_ok) level <= level - LVL_W'(1);
      end
   end

endmodule

// File: rtl/gp0_cmd_queue.sv
// GP0 command queue: buffers GP0 words, marks packet boundaries by decoding
// each head opcode, and drives the GPUSTAT ready bits and GP1 flushes.
module gp0_cmd_queue
   import gpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             to_gp0,
   input  logic             to_gp1,
   input  logic [31:0]      main_bus,
   output logic [31:0]      cmd_word,
   output logic             cmd_valid,
   output logic             cmd_first,
   output logic             cmd_last,
   input  logic             cmd_ack,
   output logic             rdy_cmd,
   output logic             rdy_dma,
   output logic             overflow,
   output logic [LVL_W-1:0] level
);

   gp0_state_t  state, state_nxt;
   logic [19:0] rem, rem_nxt;
   logic        is_xfer, is_xfer_nxt;
   logic        shaded, shaded_nxt;
   logic        want_vtx, want_vtx_nxt;
   logic [1:0]  vcnt, vcnt_nxt;
   logic        flush, pop_fire, full, empty, drop;
   logic [3:0]  head_len;
   logic        head_poly, term;

   assign flush    = to_gp1 && (main_bus[31:24] == GP1_RESET || main_bus[31:24] == GP1_CMDRST);
   assign cmd_valid = !empty;
   assign pop_fire = cmd_valid && cmd_ack && !flush;
   assign drop     = to_gp0 && full && !pop_fire && !flush;

   gp0_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .push  (to_gp0),
      .wdata (main_bus),
      .pop   (pop_fire),
      .rdata (cmd_word),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign head_len  = gp0_len(cmd_word);
   assign head_poly = (cmd_word[31:29] == OPC_LINE) && cmd_word[27];
   assign term      = (cmd_word & POLYLINE_TERM_MASK) == POLYLINE_TERM_VAL;
   assign cmd_first = cmd_valid && (state == HEAD);
   assign rdy_cmd   = empty && (state == HEAD);
   assign rdy_dma   = level < LVL_W'(DEPTH - 1);

   always_comb begin
      state_nxt    = state;
      rem_nxt      = rem;
      is_xfer_nxt  = is_xfer;
      shaded_nxt   = shaded;
      want_vtx_nxt = want_vtx;
      vcnt_nxt     = vcnt;
      cmd_last     = 1'b0;
      case (state)
         HEAD: begin
            cmd_last = cmd_valid && !head_poly && (head_len == 4'd1);
            if (pop_fire) begin
               if (head_poly) begin
                  state_nxt    = POLYLINE;
                  shaded_nxt   = cmd_word[28];
                  want_vtx_nxt = 1'b1;
                  vcnt_nxt     = 2'd0;
               end else if (head_len != 4'd1) begin
                  state_nxt   = PARAM;
                  rem_nxt     = {16'd0, head_len} - 20'd1;
                  is_xfer_nxt = (cmd_word[31:29] == OPC_CPU2VRAM);
               end
            end
         end
         PARAM: begin
            // Size word of a CPU->VRAM packet hands over to the data phase instead of ending it.
            cmd_last = cmd_valid && (rem == 20'd1) && !is_xfer;
            if (pop_fire) begin
               if (rem != 20'd1) begin
                  rem_nxt = rem - 20'd1;
               end else if (is_xfer) begin
                  rem_nxt   = xfer_words(cmd_word[9:0], cmd_word[24:16]);
                  state_nxt = XFER;
               end else begin
                  state_nxt = HEAD;
               end
            end
         end
         XFER: begin
            cmd_last = cmd_valid && (rem == 20'd1);
            if (pop_fire) begin
               if (rem == 20'd1) state_nxt = HEAD;
               else              rem_nxt   = rem - 20'd1;
            end
         end
         POLYLINE: begin
            cmd_last = cmd_valid && term && (vcnt == 2'd2);
            if (pop_fire) begin
               if (cmd_last) begin
                  state_nxt = HEAD;
               end else begin
                  // Shaded polylines interleave colour words between vertices.
                  if ((!shaded || want_vtx) && vcnt != 2'd2) vcnt_nxt = vcnt + 2'd1;
                  if (shaded) want_vtx_nxt = !want_vtx;
               end
            end
         end
         default: state_nxt = HEAD;
      endcase
      if (flush) state_nxt = HEAD;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HEAD;
         rem      <= '0;
         is_xfer  <= 1'b0;
         shaded   <= 1'b0;
         want_vtx <= 1'b0;
         vcnt     <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         rem      <= rem_nxt;
         is_xfer  <= is_xfer_nxt;
         shaded   <= shaded_nxt;
         want_vtx <= want_vtx_nxt;
         vcnt     <= vcnt_nxt;
         if (to_gp1 && main_bus[31:24] == GP1_RESET) overflow <= 1'b0;
         else if (drop)                              overflow <= 1'b1;
      end
   end

endmodule
